// File: rtl/segdecode_scan_master.sv
// Frame generator for the segment-decode SPI slave.
// Refreshes four hex digits, one per frame, and scans one key column per frame.
// Each key is debounced over several frames and a press is reported with a pulse.
module segdecode_scan_master #(
    parameter int GAP_CYCLES = 16,  // idle cycles between frames, 2..255
    parameter int DEBOUNCE   = 4    // agreeing samples to change a key, 1..15
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       scan_en,
    input  logic       digit_wr,
    input  logic [1:0] digit_addr,
    input  logic [3:0] digit_data,
    output logic       mosi,
    output logic       en,
    input  logic       miso,
    output logic [3:0] key_state,
    output logic       key_valid,
    output logic [1:0] key_code,
    output logic       busy
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        LOAD  = 2'd1,
        SHIFT = 2'd2,
        GAP   = 2'd3
    } state_t;

    localparam logic [7:0] GAP_LAST = 8'(GAP_CYCLES - 1);
    localparam logic [3:0] DEB_MAX  = 4'(DEBOUNCE);

    state_t     state;
    logic [1:0] idx;          // frame index: digit, screen and key column
    logic [2:0] bit_cnt;      // bits already sent in SHIFT
    logic [7:0] gap_cnt;      // cycles already spent in GAP
    logic [7:0] shift_reg;    // remaining frame bits, next bit at [7]
    logic [3:0] digit_q [4];
    logic [3:0] deb_cnt [4];
    logic [7:0] frame;
    logic       raw;

    // Frame layout: column select, screen select, then the hex digit.
    assign frame = {idx, idx, digit_q[idx]};
    // The slave pulls miso low while the selected key column is active.
    assign raw   = ~miso;

    // Digit register file, writable at any time.
    // NOTE: the digit registers are reset so the display comes up blank; this
    // keeps them as plain flops instead of a RAM, which is fine at 16 bits.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < 4; i++) digit_q[i] <= '0;
        end else if (digit_wr) begin
            digit_q[digit_addr] <= digit_data;
        end
    end

    // Frame sequencer with registered outputs and per-key debounce.
    // NOTE: all state here uses non-blocking assignments so every branch reads
    // the pre-edge values, e.g. the debounce compares against the old key_state.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            idx       <= '0;
            bit_cnt   <= '0;
            gap_cnt   <= '0;
            shift_reg <= '0;
            en        <= 1'b0;
            mosi      <= 1'b0;
            busy      <= 1'b0;
            key_valid <= 1'b0;
            key_code  <= '0;
            key_state <= '0;
            for (int i = 0; i < 4; i++) deb_cnt[i] <= '0;
        end else begin
            // key_valid is a single-cycle pulse unless re-raised below.
            key_valid <= 1'b0;
            case (state)
                IDLE: begin
                    if (scan_en) begin
                        state <= LOAD;
                        busy  <= 1'b1;
                    end
                end

                LOAD: begin
                    // Snapshot the frame so later digit writes cannot disturb it.
                    shift_reg <= {frame[6:0], 1'b0};
                    mosi      <= frame[7];
                    en        <= 1'b1;
                    bit_cnt   <= '0;
                    state     <= SHIFT;
                end

                SHIFT: begin
                    if (bit_cnt == 3'd7) begin
                        en      <= 1'b0;
                        mosi    <= 1'b0;
                        gap_cnt <= '0;
                        state   <= GAP;
                    end else begin
                        mosi      <= shift_reg[7];
                        shift_reg <= {shift_reg[6:0], 1'b0};
                        bit_cnt   <= bit_cnt + 3'd1;
                    end
                end

                GAP: begin
                    if (gap_cnt == GAP_LAST) begin
                        // Single miso sample per frame, for key column idx.
                        if (raw != key_state[idx]) begin
                            if (deb_cnt[idx] + 4'd1 == DEB_MAX) begin
                                key_state[idx] <= raw;
                                deb_cnt[idx]   <= '0;
                                if (raw) begin
                                    key_valid <= 1'b1;
                                    key_code  <= idx;
                                end
                            end else begin
                                deb_cnt[idx] <= deb_cnt[idx] + 4'd1;
                            end
                        end else begin
                            deb_cnt[idx] <= '0;
                        end
                        idx <= idx + 2'd1;
                        if (scan_en) begin
                            state <= LOAD;
                        end else begin
                            state <= IDLE;
                            busy  <= 1'b0;
                        end
                    end else begin
                        gap_cnt <= gap_cnt + 8'd1;
                    end
                end

                default: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_segdecode_scan_master.sv
// Self-checking bench for segdecode_scan_master: directed scenarios plus a
// randomized stretch, checked against a frame-level behavioural model.
module tb_segdecode_scan_master;

    localparam int G = 16;
    localparam int D = 4;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       scan_en;
    logic       digit_wr;
    logic [1:0] digit_addr;
    logic [3:0] digit_data;
    logic       mosi;
    logic       en;
    logic       miso;
    logic [3:0] key_state;
    logic       key_valid;
    logic [1:0] key_code;
    logic       busy;

    segdecode_scan_master #(.GAP_CYCLES(G), .DEBOUNCE(D)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .scan_en    (scan_en),
        .digit_wr   (digit_wr),
        .digit_addr (digit_addr),
        .digit_data (digit_data),
        .mosi       (mosi),
        .en         (en),
        .miso       (miso),
        .key_state  (key_state),
        .key_valid  (key_valid),
        .key_code   (key_code),
        .busy       (busy)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=0x%0h exp=0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Cycle counter and key_valid pulse monitor.
    int         cyc = 0;
    int         pulses = 0;
    logic [1:0] seen_code = 2'd0;
    always @(posedge clk) cyc++;
    always @(negedge clk) begin
        if (key_valid === 1'b1) begin
            pulses++;
            seen_code = key_code;
        end
    end

    // Behavioural model, one step per frame.
    logic [3:0] m_dig [4];
    int         m_idx;
    logic [3:0] m_state;
    int         m_run [4];
    int         m_pulses = 0;
    int         m_code;
    int         prev_rise;
    bit         cont;
    logic [7:0] last_frame;

    task automatic model_reset();
        for (int i = 0; i < 4; i++) begin
            m_dig[i] = 4'd0;
            m_run[i] = 0;
        end
        m_idx   = 0;
        m_state = 4'd0;
        m_code  = 0;
        cont    = 1'b0;
    endtask

    // One debounce sample for key m_idx: D consecutive disagreeing samples flip it.
    task automatic model_sample(input bit pressed);
        int k;
        k = m_idx;
        if (pressed != m_state[k]) begin
            m_run[k]++;
            if (m_run[k] == D) begin
                m_state[k] = pressed;
                m_run[k]   = 0;
                if (pressed) begin
                    m_pulses++;
                    m_code = k;
                end
            end
        end else begin
            m_run[k] = 0;
        end
        m_idx = (m_idx + 1) % 4;
    endtask

    task automatic wr_digit(input logic [1:0] a, input logic [3:0] d);
        @(negedge clk);
        digit_wr   = 1'b1;
        digit_addr = a;
        digit_data = d;
        m_dig[a]   = d;
        @(negedge clk);
        digit_wr   = 1'b0;
    endtask

    // Follow one frame: wait for en, capture 8 bits, check the gap and the
    // key result. Optional actions at a given SHIFT bit: drop scan_en, pulse
    // reset, or write a digit. Returns at the negedge just after the GAP.
    task automatic do_frame(input bit key_low, input int drop_bit, input int rst_bit,
                            input int wr_bit, input logic [1:0] wa, input logic [3:0] wd);
        int         waited;
        int         en_cnt;
        int         gap_bad;
        logic [7:0] exp_f;
        logic [7:0] got_f;
        waited = 0;
        while (en !== 1'b1 && waited < 200) begin
            @(negedge clk);
            waited++;
        end
        if (waited >= 200) begin
            check("en_timeout", 32'd0, 32'd1);
            return;
        end
        if (cont) check("period", cyc - prev_rise, 9 + G);
        prev_rise = cyc;
        cont      = 1'b1;
        exp_f     = 8'(m_idx * 8'h50 + int'(m_dig[m_idx]));
        miso      = key_low ? 1'b0 : 1'b1;
        en_cnt    = 0;
        got_f     = 8'h00;
        for (int i = 0; i < 8; i++) begin
            if (i > 0) @(negedge clk);
            if (en === 1'b1) en_cnt++;
            got_f[7 - i] = mosi;
            if (i == rst_bit) begin
                rst_n = 1'b0;
                #1;
                check("rst_en", en, 1'b0);
                check("rst_keys", key_state, 4'd0);
                check("rst_busy", busy, 1'b0);
                check("rst_mosi", mosi, 1'b0);
                @(negedge clk);
                @(negedge clk);
                rst_n = 1'b1;
                miso  = 1'b1;
                model_reset();
                return;
            end
            if (i == drop_bit) scan_en = 1'b0;
            if (i == wr_bit) begin
                digit_wr   = 1'b1;
                digit_addr = wa;
                digit_data = wd;
                m_dig[wa]  = wd;
            end else begin
                digit_wr = 1'b0;
            end
        end
        @(negedge clk);
        digit_wr = 1'b0;
        check("en_high_cycles", en_cnt, 8);
        check("frame", got_f, exp_f);
        last_frame = got_f;
        gap_bad = 0;
        for (int j = 0; j < G; j++) begin
            if (en !== 1'b0 || mosi !== 1'b0 || busy !== 1'b1) gap_bad++;
            @(negedge clk);
        end
        #1;
        check("gap_quiet", gap_bad, 0);
        model_sample(key_low);
        check("key_state", key_state, m_state);
        check("pulses", pulses, m_pulses);
        check("key_code", key_code, m_code);
        check("busy_after", busy, scan_en ? 1 : 0);
        if (!scan_en) cont = 1'b0;
    endtask

    logic [7:0] exp_tab [4];

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int cnt;
        exp_tab[0] = 8'h01;
        exp_tab[1] = 8'h52;
        exp_tab[2] = 8'hA3;
        exp_tab[3] = 8'hF4;
        rst_n      = 1'b0;
        scan_en    = 1'b0;
        digit_wr   = 1'b0;
        digit_addr = 2'd0;
        digit_data = 4'd0;
        miso       = 1'b1;
        model_reset();
        repeat (3) @(negedge clk);
        check("reset_en", en, 1'b0);
        check("reset_mosi", mosi, 1'b0);
        check("reset_busy", busy, 1'b0);
        check("reset_key_state", key_state, 4'd0);
        check("reset_key_valid", key_valid, 1'b0);
        check("reset_key_code", key_code, 2'd0);
        rst_n = 1'b1;

        // Digits 1..4, continuous scan: known frames and period.
        for (int a = 0; a < 4; a++) wr_digit(2'(a), 4'(a + 1));
        scan_en = 1'b1;
        for (int f = 0; f < 4; f++) begin
            do_frame(1'b0, -1, -1, -1, 2'd0, 4'd0);
            check("frame_table", last_frame, exp_tab[f]);
        end

        // Key 1 low for three samples then released: no press.
        for (int r = 0; r < 4; r++)
            for (int f = 0; f < 4; f++)
                do_frame(m_idx == 1 && r < 3, -1, -1, -1, 2'd0, 4'd0);
        check("short_press_state", key_state, 4'd0);
        check("short_press_pulses", pulses, 0);

        // Key 2 low for D consecutive samples: one press on key 2.
        for (int r = 0; r < D; r++)
            for (int f = 0; f < 4; f++)
                do_frame(m_idx == 2, -1, -1, -1, 2'd0, 4'd0);
        check("press_state", key_state, 4'b0100);
        check("press_pulses", pulses, 1);
        check("press_code", key_code, 2'd2);

        // Digit 0 written mid-SHIFT of its own frame: old value in flight.
        do_frame(1'b0, -1, -1, 2, 2'd0, 4'd9);
        check("wr_inflight_old", last_frame, 8'h01);
        for (int f = 0; f < 3; f++) do_frame(m_idx == 2, -1, -1, -1, 2'd0, 4'd0);
        do_frame(1'b0, -1, -1, -1, 2'd0, 4'd0);
        check("wr_inflight_new", last_frame, 8'h09);

        // Randomized keys and in-flight digit writes.
        for (int f = 0; f < 32; f++)
            do_frame($urandom_range(0, 99) < 55, -1, -1, int'($urandom_range(0, 9)),
                     2'($urandom_range(0, 3)), 4'($urandom_range(0, 15)));

        // Drop scan_en during the SHIFT of idx 1: frame and gap complete.
        while (m_idx != 1) do_frame(1'b0, -1, -1, -1, 2'd0, 4'd0);
        do_frame(1'b0, 3, -1, -1, 2'd0, 4'd0);
        cnt = 0;
        for (int c = 0; c < 40; c++) begin
            @(negedge clk);
            if (en !== 1'b0 || busy !== 1'b0) cnt++;
        end
        check("stopped_quiet", cnt, 0);

        // Press every key, then reset mid-SHIFT.
        scan_en = 1'b1;
        for (int f = 0; f < 4 * D; f++) do_frame(1'b1, -1, -1, -1, 2'd0, 4'd0);
        check("all_pressed", key_state, 4'hF);
        do_frame(1'b1, -1, 3, -1, 2'd0, 4'd0);
        do_frame(1'b0, -1, -1, -1, 2'd0, 4'd0);
        check("after_reset_idx0", last_frame, 8'h00);
        do_frame(1'b0, -1, -1, -1, 2'd0, 4'd0);
        check("after_reset_idx1", last_frame, 8'h50);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
